// File: rtl/freq_sweep_pkg.sv
// -----------------------------------------------------------------------------
// freq_sweep_pkg
// Shared definitions for the frequency sweep controller: FSM state encoding,
// sweep mode codes and default field widths.
// Ports: none (package).
// -----------------------------------------------------------------------------
package freq_sweep_pkg;

    localparam int FREQ_W_DEF  = 13;
    localparam int DWELL_W_DEF = 16;

    // The step decision is folded into the last dwell edge, so only two states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    // Mode 3 is not listed: it falls through to single-shot behaviour.
    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_sweep_ctrl_if
// Sweep configuration channel (valid/ready handshake plus config fields).
// Modports:
//   master : offers configuration (drives cfg_valid and cfg_* fields)
//   slave  : accepts configuration (drives cfg_ready)
// -----------------------------------------------------------------------------
interface freq_sweep_ctrl_if
    import freq_sweep_pkg::*;
#(
    parameter int FREQ_WIDTH  = FREQ_W_DEF,
    parameter int DWELL_WIDTH = DWELL_W_DEF
);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [FREQ_WIDTH-1:0]  cfg_f_start;
    logic [FREQ_WIDTH-1:0]  cfg_f_stop;
    logic [FREQ_WIDTH-1:0]  cfg_f_step;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic [1:0]             cfg_mode;

    modport master (
        output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/freq_sweep_step.sv
// -----------------------------------------------------------------------------
// freq_sweep_step
// Combinational next-frequency calculation for one sweep step. Arithmetic is
// done one bit wider than the frequency word so an overshoot past the top of
// the range or a borrow below zero is detected and clamped to the target.
// Ports:
//   freq      in   current frequency word
//   step      in   step magnitude
//   target    in   endpoint being approached
//   dir_down  in   1 = decreasing
//   nxt_freq  out  next frequency, clamped to target
//   at_target out  current frequency equals target
// -----------------------------------------------------------------------------
module freq_sweep_step
    import freq_sweep_pkg::*;
#(
    parameter int FREQ_WIDTH = FREQ_W_DEF
) (
    input  logic [FREQ_WIDTH-1:0] freq,
    input  logic [FREQ_WIDTH-1:0] step,
    input  logic [FREQ_WIDTH-1:0] target,
    input  logic                  dir_down,
    output logic [FREQ_WIDTH-1:0] nxt_freq,
    output logic                  at_target
);

    logic [FREQ_WIDTH:0] sum;
    logic [FREQ_WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, freq} + {1'b0, step};
        diff     = {1'b0, freq} - {1'b0, step};
        nxt_freq = freq;
        if (dir_down) begin
            // diff MSB set means the subtraction borrowed below zero
            if (diff[FREQ_WIDTH] || (diff[FREQ_WIDTH-1:0] <= target)) begin
                nxt_freq = target;
            end else begin
                nxt_freq = diff[FREQ_WIDTH-1:0];
            end
        end else begin
            if (sum >= {1'b0, target}) begin
                nxt_freq = target;
            end else begin
                nxt_freq = sum[FREQ_WIDTH-1:0];
            end
        end
    end

    assign at_target = (freq == target);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sweep_ctrl
// Drives the CORDIC generator freq word with stepped frequency sweeps.
// A configuration is loaded over the cfg channel while idle; start then walks
// freq from f_start to f_stop, holding each value (cfg_dwell+1) clocks.
// Modes: single (done pulse at end), repeat (sawtooth), triangle (up/down).
// Ports:
//   clock     in   system clock
//   resetn    in   asynchronous active-low reset
//   cfg       slave modport of freq_sweep_ctrl_if (config handshake)
//   start     in   level-sampled sweep start (idle with loaded config)
//   abort     in   stop sweep, return to idle, freq holds
//   freq      out  registered frequency word
//   busy      out  sweep in progress
//   done      out  one-cycle pulse at end of a single-mode sweep
//   dir_down  out  current step direction (1 = decreasing)
// -----------------------------------------------------------------------------
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int FREQ_WIDTH  = FREQ_W_DEF,
    parameter int DWELL_WIDTH = DWELL_W_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    freq_sweep_ctrl_if.slave      cfg,
    input  logic                  start,
    input  logic                  abort,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  busy,
    output logic                  done,
    output logic                  dir_down
);

    state_t                 state;
    logic                   cfg_loaded;
    logic [FREQ_WIDTH-1:0]  f_start_r;
    logic [FREQ_WIDTH-1:0]  f_stop_r;
    logic [FREQ_WIDTH-1:0]  f_step_r;
    logic [DWELL_WIDTH-1:0] dwell_r;
    logic [1:0]             mode_r;
    logic [FREQ_WIDTH-1:0]  target_r;
    logic [DWELL_WIDTH-1:0] dwell_cnt;

    logic [FREQ_WIDTH-1:0]  fwd_nxt;
    logic                   fwd_at;
    logic [FREQ_WIDTH-1:0]  rev_target;
    logic [FREQ_WIDTH-1:0]  rev_nxt;
    logic                   rev_at_unused;

    // Continue toward the current endpoint.
    freq_sweep_step #(.FREQ_WIDTH(FREQ_WIDTH)) u_step_fwd (
        .freq      (freq),
        .step      (f_step_r),
        .target    (target_r),
        .dir_down  (dir_down),
        .nxt_freq  (fwd_nxt),
        .at_target (fwd_at)
    );

    // Triangle turnaround: the first step away from the endpoint is taken on
    // the same edge the direction flips, so the endpoint is not dwelt twice.
    assign rev_target = (target_r == f_stop_r) ? f_start_r : f_stop_r;

    freq_sweep_step #(.FREQ_WIDTH(FREQ_WIDTH)) u_step_rev (
        .freq      (freq),
        .step      (f_step_r),
        .target    (rev_target),
        .dir_down  (~dir_down),
        .nxt_freq  (rev_nxt),
        .at_target (rev_at_unused)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cfg_loaded    <= 1'b0;
            f_start_r     <= '0;
            f_stop_r      <= '0;
            f_step_r      <= '0;
            dwell_r       <= '0;
            mode_r        <= MODE_SINGLE;
            target_r      <= '0;
            dwell_cnt     <= '0;
            freq          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            dir_down      <= 1'b0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort > config handshake > start
                    if (abort) begin
                        busy <= 1'b0;
                    end else if (cfg.cfg_valid && cfg.cfg_ready) begin
                        f_start_r  <= cfg.cfg_f_start;
                        f_stop_r   <= cfg.cfg_f_stop;
                        f_step_r   <= cfg.cfg_f_step;
                        dwell_r    <= cfg.cfg_dwell;
                        mode_r     <= cfg.cfg_mode;
                        cfg_loaded <= 1'b1;
                    end else if (start && cfg_loaded) begin
                        freq          <= f_start_r;
                        target_r      <= f_stop_r;
                        dir_down      <= (f_start_r > f_stop_r);
                        dwell_cnt     <= dwell_r;
                        busy          <= 1'b1;
                        cfg.cfg_ready <= 1'b0;
                        state         <= ST_DWELL;
                    end
                end

                ST_DWELL: begin
                    if (abort) begin
                        busy          <= 1'b0;
                        cfg.cfg_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                    end else begin
                        dwell_cnt <= dwell_r;
                        if (!fwd_at) begin
                            freq <= fwd_nxt;
                        end else begin
                            case (mode_r)
                                MODE_REPEAT: begin
                                    freq <= f_start_r;
                                end
                                MODE_TRIANGLE: begin
                                    // Degenerate range: nothing to bounce between, hold.
                                    if (f_start_r != f_stop_r) begin
                                        target_r <= rev_target;
                                        dir_down <= ~dir_down;
                                        freq     <= rev_nxt;
                                    end
                                end
                                default: begin
                                    done          <= 1'b1;
                                    busy          <= 1'b0;
                                    cfg.cfg_ready <= 1'b1;
                                    state         <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_sweep_ctrl
// Directed and randomized sweeps checked cycle by cycle against a reference
// model that builds the expected freq/busy/done/dir_down trace as a list of
// plateau values, each repeated (dwell+1) times.
// -----------------------------------------------------------------------------
module tb_freq_sweep_ctrl;

    localparam int FW = 13;
    localparam int DW = 16;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [FW-1:0] freq;
    logic          busy;
    logic          done;
    logic          dir_down;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   f;
        logic b;
        logic d;
        logic dn;
    } exp_t;

    exp_t model_q[$];

    freq_sweep_ctrl_if #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW)) cfg_if ();

    freq_sweep_ctrl #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .cfg      (cfg_if),
        .start    (start),
        .abort    (abort),
        .freq     (freq),
        .busy     (busy),
        .done     (done),
        .dir_down (dir_down)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One step toward tgt, never passing it.
    function automatic int toward(input int cur, input int st, input int tgt, input logic dn);
        int n;
        if (dn) begin
            n = cur - st;
            return (n < tgt) ? tgt : n;
        end else begin
            n = cur + st;
            return (n > tgt) ? tgt : n;
        end
    endfunction

    task automatic build_model(input int fs, input int ft, input int st, input int dw,
                               input int md, input int ncyc);
        int   cur;
        int   tgt;
        logic dn;
        exp_t e;
        model_q.delete();
        cur = fs;
        tgt = ft;
        dn  = (fs > ft);
        while (model_q.size() < ncyc) begin
            for (int r = 0; r <= dw; r++) begin
                e = '{f: cur, b: 1'b1, d: 1'b0, dn: dn};
                model_q.push_back(e);
            end
            if (cur != tgt) begin
                cur = toward(cur, st, tgt, dn);
            end else if (md == 1) begin
                cur = fs;
            end else if (md == 2) begin
                if (fs != ft) begin
                    tgt = (tgt == ft) ? fs : ft;
                    dn  = !dn;
                    cur = toward(cur, st, tgt, dn);
                end
            end else begin
                e = '{f: cur, b: 1'b0, d: 1'b1, dn: dn};
                model_q.push_back(e);
                while (model_q.size() < ncyc) begin
                    e = '{f: cur, b: 1'b0, d: 1'b0, dn: dn};
                    model_q.push_back(e);
                end
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_cfg(input int fs, input int ft, input int st, input int dw, input int md);
        chk("cfg_ready_idle", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_f_start = FW'(fs);
        cfg_if.cfg_f_stop  = FW'(ft);
        cfg_if.cfg_f_step  = FW'(st);
        cfg_if.cfg_dwell   = DW'(dw);
        cfg_if.cfg_mode    = 2'(md);
        @(posedge clock); #1;
        cfg_if.cfg_valid   = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input int fs, input int ft, input int st,
                             input int dw, input int md, input int ncyc, input bit poke);
        send_cfg(fs, ft, st, dw, md);
        build_model(fs, ft, st, dw, md, ncyc);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            chk({tag, "_freq"},  32'(freq),             32'(model_q[k].f));
            chk({tag, "_busy"},  32'(busy),             32'(model_q[k].b));
            chk({tag, "_done"},  32'(done),             32'(model_q[k].d));
            chk({tag, "_dir"},   32'(dir_down),         32'(model_q[k].dn));
            chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'(!model_q[k].b));
            // Offer a conflicting config while the sweep must stall it.
            cfg_if.cfg_valid = 1'b0;
            if (poke && model_q[k].b && (k + 1 < ncyc) && model_q[k+1].b) begin
                cfg_if.cfg_valid   = 1'b1;
                cfg_if.cfg_f_start = FW'($urandom);
                cfg_if.cfg_f_stop  = FW'($urandom);
                cfg_if.cfg_f_step  = FW'($urandom);
                cfg_if.cfg_dwell   = DW'($urandom);
                cfg_if.cfg_mode    = 2'($urandom);
            end
        end
        cfg_if.cfg_valid = 1'b0;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_done"}, 32'(done), 32'd0);
        chk({tag, "_abort_freq"}, 32'(freq), 32'(model_q[ncyc-1].f));
    endtask

    initial begin
        int fs, ft, st, dw, md;
        logic [FW-1:0] held;

        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_f_start = '0;
        cfg_if.cfg_f_stop  = '0;
        cfg_if.cfg_f_step  = '0;
        cfg_if.cfg_dwell   = '0;
        cfg_if.cfg_mode    = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_freq",  32'(freq),             32'd0);
        chk("rst_busy",  32'(busy),             32'd0);
        chk("rst_done",  32'(done),             32'd0);
        chk("rst_dir",   32'(dir_down),         32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clock); #1;

        // start without any loaded config must be ignored
        start = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("nocfg_busy", 32'(busy), 32'd0);
            chk("nocfg_freq", 32'(freq), 32'd0);
        end
        start = 1'b0;

        run_sweep("single_up", 100, 130, 10, 2, 0, 16, 1'b0);
        run_sweep("down_clamp", 50, 20, 20, 0, 0, 6, 1'b0);
        run_sweep("triangle", 0, 30, 10, 0, 2, 16, 1'b1);
        run_sweep("repeat_top", 8190, 8191, 4, 0, 1, 10, 1'b1);
        run_sweep("equal_single", 77, 77, 5, 1, 3, 5, 1'b0);
        run_sweep("equal_tri", 500, 500, 5, 0, 2, 5, 1'b0);
        run_sweep("zero_step", 40, 90, 0, 1, 1, 8, 1'b0);
        run_sweep("tri_wide_step", 8000, 10, 5000, 1, 2, 14, 1'b1);

        for (int i = 0; i < 8; i++) begin
            fs = int'($urandom_range(0, 8191));
            ft = ($urandom_range(0, 4) == 0) ? fs : int'($urandom_range(0, 8191));
            st = int'($urandom_range(0, 3000));
            dw = int'($urandom_range(0, 2));
            md = int'($urandom_range(0, 3));
            run_sweep("rand", fs, ft, st, dw, md, 30, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a dwell
        send_cfg(200, 260, 20, 3, 1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        held = freq;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_freq", 32'(held), 32'd220);
        resetn = 1'b0;
        #1;
        chk("arst_freq",  32'(freq),             32'd0);
        chk("arst_busy",  32'(busy),             32'd0);
        chk("arst_dir",   32'(dir_down),         32'd0);
        chk("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b1;
        start  = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("postrst_busy", 32'(busy), 32'd0);
            chk("postrst_freq", 32'(freq), 32'd0);
        end
        start = 1'b0;

        // A fresh config makes start work again
        run_sweep("after_rst", 300, 260, 15, 0, 0, 6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
